srt_prenorm: RTL and testbench

SRT_PRENORM -- requirements
Module: srt_prenorm

---
 rtl/srt_pkg.sv | 27 ++
 rtl/srt_norm_shift.sv | 45 ++++
 rtl/srt_prenorm.sv | 106 ++++++++++
 tb/tb_srt_prenorm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/srt_pkg.sv
// Shared constants and control-state encoding for the SRT divider front end.
// Build option: SRT_PRENORM_DZ_EN adds the divide-by-zero state.
// Shared by srt_prenorm and the divider control.
package srt_pkg;

    localparam int OP_W = 8;
    localparam int SH_W = 3;
    localparam logic [SH_W-1:0] SH_MAX = SH_W'(OP_W - 1);

`ifdef SRT_PRENORM_DZ_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DZ    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3
    } state_t;
`endif

endpackage

// File: rtl/srt_norm_shift.sv
// Divisor normalizer: holds the divisor and its shift count, shifting left one bit per enabled cycle.
// Latency: one bit per cycle; norm_done once the MSB is set or the count reaches SH_MAX.
// Backpressure: none; load has priority over shift_en.
module srt_norm_shift
    import srt_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic [OP_W-1:0] load_val,
    input  logic            shift_en,
    output logic [OP_W-1:0] d_q,
    output logic [SH_W-1:0] shamt_q,
    output logic            norm_done
);

    logic [OP_W-1:0] d_d;
    logic [SH_W-1:0] shamt_d;

    // Saturating at SH_MAX is what stops a zero divisor from shifting forever.
    assign norm_done = d_q[OP_W-1] | (shamt_q == SH_MAX);

    always_comb begin
        d_d     = d_q;
        shamt_d = shamt_q;
        if (load) begin
            d_d     = load_val;
            shamt_d = '0;
        end else if (shift_en && !norm_done) begin
            d_d     = {d_q[OP_W-2:0], 1'b0};
            shamt_d = shamt_q + SH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            d_q     <= '0;
            shamt_q <= '0;
        end else begin
            d_q     <= d_d;
            shamt_q <= shamt_d;
        end
    end

endmodule

// File: rtl/srt_prenorm.sv
// SRT pre-normalizer: accepts n/d, left-justifies d, then pulses start and waits for div_done.
// Latency: start is high k+2 cycles after accept, k = leading zeros of d_in (capped at 7).
// Backpressure: in_ready only in IDLE; in_valid is ignored while busy. SRT_PRENORM_DZ_EN adds dz_err.
module srt_prenorm
    import srt_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] n_in,
    input  logic [OP_W-1:0] d_in,
    output logic [OP_W-1:0] n_out,
    output logic [OP_W-1:0] d_out,
    output logic [SH_W-1:0] shamt,
    output logic            start,
    input  logic            div_done
`ifdef SRT_PRENORM_DZ_EN
    ,
    output logic            dz_err
`endif
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] n_q, n_d;
    logic            load;
    logic            shift_en;
    logic            norm_done;
    logic [OP_W-1:0] d_q;
    logic [SH_W-1:0] shamt_q;

    srt_norm_shift u_norm (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .load_val  (d_in),
        .shift_en  (shift_en),
        .d_q       (d_q),
        .shamt_q   (shamt_q),
        .norm_done (norm_done)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        load     = 1'b0;
        shift_en = 1'b0;
        in_ready = 1'b0;
        start    = 1'b0;
`ifdef SRT_PRENORM_DZ_EN
        dz_err   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    n_d     = n_in;
`ifdef SRT_PRENORM_DZ_EN
                    state_d = (d_in == '0) ? ST_DZ : ST_SHIFT;
`else
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (norm_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SRT_PRENORM_DZ_EN
            ST_DZ: begin
                dz_err  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
        end
    end

    // The dividend is never shifted; the consumer undoes the divisor shift on the results.
    assign n_out = n_q;
    assign d_out = d_q;
    assign shamt = shamt_q;

endmodule

// File: tb/tb_srt_prenorm.sv
// Bench for srt_prenorm: directed and random operand pairs checked against a leading-zero model.
// Honours SRT_PRENORM_DZ_EN when defined.
module tb_srt_prenorm;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] n_in = 8'h00;
    logic [7:0] d_in = 8'h00;
    logic [7:0] n_out;
    logic [7:0] d_out;
    logic [2:0] shamt;
    logic       start;
    logic       div_done = 1'b0;
`ifdef SRT_PRENORM_DZ_EN
    logic       dz_err;
`endif

    srt_prenorm dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .n_in     (n_in),
        .d_in     (d_in),
        .n_out    (n_out),
        .d_out    (d_out),
        .shamt    (shamt),
        .start    (start),
        .div_done (div_done)
`ifdef SRT_PRENORM_DZ_EN
        ,
        .dz_err   (dz_err)
`endif
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [2:0] sh;
        int         start_edge;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Leading zeros of d, capped at 7 (a zero divisor counts as 7).
    function automatic int lead_zeros(input logic [7:0] d);
        int msb = 0;
        if (d == 8'h00) return 7;
        for (int v = int'(d); v > 1; v = v / 2) msb++;
        return 7 - msb;
    endfunction

    function automatic logic [7:0] normed(input logic [7:0] d, input int k);
        return 8'((int'(d) * (1 << k)) % 256);
    endfunction

    // Monitor: every start pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (start === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_start", 32'(start), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("start_n_out", 32'(n_out), 32'(e.n));
                chk("start_d_out", 32'(d_out), 32'(e.d));
                chk("start_shamt", 32'(shamt), 32'(e.sh));
                chk("start_edge", 32'(edge_cnt + 1), 32'(e.start_edge));
            end
        end
    end

    task automatic txn(input logic [7:0] n, input logic [7:0] d, input int hold, input bit inject);
        int         k;
        int         t_acc;
        logic [7:0] dn;
        bit         got;
        k  = lead_zeros(d);
        dn = normed(d, k);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        n_in     = n;
        d_in     = d;
        @(negedge clk);
        in_valid = 1'b0;
        n_in     = 8'($urandom);
        d_in     = 8'($urandom);
        t_acc    = edge_cnt;
`ifdef SRT_PRENORM_DZ_EN
        if (d == 8'h00) begin
            chk("dz_err_pulse", 32'(dz_err), 32'd1);
            chk("dz_no_start", 32'(start), 32'd0);
            @(negedge clk);
            chk("dz_err_one_cycle", 32'(dz_err), 32'd0);
            chk("dz_back_idle", 32'(in_ready), 32'd1);
            return;
        end
`endif
        sb.push_back('{n, dn, 3'(k), t_acc + 2 + k});
        got = 1'b0;
        // div_done noise while normalizing must have no effect.
        for (int i = 0; i < 20 && !got; i++) begin
            div_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (start === 1'b1) got = 1'b1;
        end
        div_done = 1'b0;
        chk("start_seen", 32'(got), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (inject && h == hold / 2) begin
                in_valid = 1'b1;
                n_in     = 8'($urandom);
                d_in     = 8'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
            chk("hold_n_out", 32'(n_out), 32'(n));
            chk("hold_d_out", 32'(d_out), 32'(dn));
            chk("hold_shamt", 32'(shamt), 32'(k));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_start", 32'(start), 32'd0);
        end
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_d_out", 32'(d_out), 32'(dn));
        chk("done_shamt", 32'(shamt), 32'(k));
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        in_valid = 1'b1;
        n_in     = 8'h5A;
        d_in     = 8'h04;
        @(negedge clk);
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        chk("rst_n_out", 32'(n_out), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        chk("rst_shamt", 32'(shamt), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        chk("rst_release_d_out", 32'(d_out), 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_still_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_n_out", 32'(n_out), 32'd0);
        chk("reset_d_out", 32'(d_out), 32'd0);
        chk("reset_shamt", 32'(shamt), 32'd0);
        chk("reset_start", 32'(start), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SRT_PRENORM_DZ_EN
        chk("reset_dz_err", 32'(dz_err), 32'd0);
`endif
        resetn = 1'b1;

        txn(8'hC8, 8'h80, 2, 1'b0);
        txn(8'h3C, 8'h01, 3, 1'b0);
        txn(8'hA7, 8'h13, 10, 1'b0);
        txn(8'h11, 8'h13, 4, 1'b1);
        reset_mid_shift();
        txn(8'h77, 8'h00, 2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            txn(8'($urandom), 8'($urandom_range(0, 255) >> $urandom_range(0, 7)),
                $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fails);
        $fatal(1, "watchdog expired");
    end

endmodule
